// File: rtl/ibridge_pkg.sv
// ibridge_pkg
// Shared definitions for the instruction-side sram-like to AXI read bridge:
// FSM state encoding, AXI constants and the sram size to AXI arsize mapping.
// Related build macro: IBRIDGE_RRESP_ERR_EN (used by inst_sram_axi_rd_bridge).
package ibridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    R    = 2'd2,
    WACK = 2'd3
  } ibridge_state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [1:0] SIZE_WORD      = 2'b10;

  // Size code 3 is reserved on the sram side and is issued as a word access.
  function automatic logic [2:0] size_to_arsize(input logic [1:0] size);
    logic [1:0] s;
    s = (size == 2'b11) ? SIZE_WORD : size;
    return {1'b0, s};
  endfunction

endpackage

// File: rtl/inst_sram_axi_rd_bridge.sv
// inst_sram_axi_rd_bridge
// Turns one instruction-side sram-like request at a time into a single-beat
// AXI read and returns the read data with inst_data_ok. Write requests are
// acknowledged locally one cycle after acceptance and never reach AXI.
//
// Optional build macro: IBRIDGE_RRESP_ERR_EN
//   defined   -> adds output inst_err; an R beat with rresp[1] set pulses
//                inst_err with inst_data_ok and forces inst_rdata to 0.
//   undefined -> no inst_err port, rresp is ignored.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   inst_req/wr/size/addr/wdata sram-like request (wdata ignored)
//   inst_addr_ok                request accepted this cycle (IDLE only)
//   inst_data_ok, inst_rdata    completion strobe and read data
//   arid..arvalid, arready      AXI read address channel (single beat, INCR)
//   rdata, rresp, rlast, rvalid, rready  AXI read data channel
//   dbg_state                   current FSM state, for observation only
//
// Handshake semantics: an AXI transfer happens on any rising edge where both
// valid and ready are high. arvalid and araddr/arsize stay stable from the
// cycle after acceptance until arready is seen. rready is high only in R, so
// an rvalid outside R is never consumed. On the sram side a request is taken
// in the cycle inst_req & inst_addr_ok, and the result is delivered in the
// single cycle inst_data_ok is high; inst_rdata is 0 in every other cycle.
module inst_sram_axi_rd_bridge
  import ibridge_pkg::*;
#(
  parameter int ID_WIDTH = 4,
  parameter int ARID     = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_req,
  input  logic                inst_wr,
  input  logic [1:0]          inst_size,
  input  logic [31:0]         inst_addr,
  input  logic [31:0]         inst_wdata,
  output logic [31:0]         inst_rdata,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
`ifdef IBRIDGE_RRESP_ERR_EN
  output logic                inst_err,
`endif
  output logic [ID_WIDTH-1:0] arid,
  output logic [31:0]         araddr,
  output logic [7:0]          arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  output logic                arvalid,
  input  logic                arready,
  input  logic [31:0]         rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  input  logic                rvalid,
  output logic                rready,
  output logic [1:0]          dbg_state
);

  ibridge_state_t state;
  logic           r_fire;
  logic           rd_err;

  // Inputs with no function in this bridge; collected to show they are
  // intentionally unused.
  logic unused_ok;
  assign unused_ok = ^{inst_wdata, rlast, rresp};

  assign arid      = ID_WIDTH'(ARID);
  assign arlen     = 8'd0;
  assign arburst   = AXI_BURST_INCR;
  assign dbg_state = state;

  // rready is registered and high exactly while in R.
  assign r_fire = rready & rvalid;

`ifdef IBRIDGE_RRESP_ERR_EN
  // SLVERR and DECERR both have rresp[1] set.
  assign rd_err   = r_fire & rresp[1];
  assign inst_err = ~rst & rd_err;
`else
  assign rd_err   = 1'b0;
`endif

  // Strobes are masked during the reset cycle so the outputs read as idle.
  assign inst_addr_ok = ~rst & inst_req & (state == IDLE);
  assign inst_data_ok = ~rst & (r_fire | (state == WACK));
  assign inst_rdata   = (~rst & r_fire & ~rd_err) ? rdata : 32'h0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      arvalid <= 1'b0;
      rready  <= 1'b0;
      araddr  <= 32'h0;
      arsize  <= 3'b000;
    end else begin
      case (state)
        IDLE: begin
          if (inst_req) begin
            if (inst_wr) begin
              state <= WACK;
            end else begin
              araddr  <= inst_addr;
              arsize  <= size_to_arsize(inst_size);
              arvalid <= 1'b1;
              state   <= AR;
            end
          end
        end
        AR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= R;
          end
        end
        R: begin
          if (rvalid) begin
            rready <= 1'b0;
            state  <= IDLE;
          end
        end
        WACK: begin
          state <= IDLE;
        end
        default: begin
          arvalid <= 1'b0;
          rready  <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_sram_axi_rd_bridge.sv
// tb_inst_sram_axi_rd_bridge
// Directed bench for inst_sram_axi_rd_bridge. Expected completion data is
// queued when the completing stimulus is driven; a negedge monitor pops and
// compares on every inst_data_ok. Build macro IBRIDGE_RRESP_ERR_EN enables
// the error-response case.
module tb_inst_sram_axi_rd_bridge;
  import ibridge_pkg::*;

  logic        clk;
  logic        rst;
  logic        inst_req;
  logic        inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr;
  logic [31:0] inst_wdata;
  logic [31:0] inst_rdata;
  logic        inst_addr_ok;
  logic        inst_data_ok;
`ifdef IBRIDGE_RRESP_ERR_EN
  logic        inst_err;
`endif
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  inst_sram_axi_rd_bridge #(.ID_WIDTH(4), .ARID(0)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_rdata(inst_rdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
`ifdef IBRIDGE_RRESP_ERR_EN
    .inst_err(inst_err),
`endif
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every data_ok consumes one expected entry.
  always @(negedge clk) begin
    if (inst_data_ok === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_data_ok actual=1 expected=0 rdata=%h", inst_rdata);
      end else begin
        chk("rdata_on_data_ok", inst_rdata, exp_q.pop_front());
      end
    end else begin
      chk("rdata_zero_idle", inst_rdata, 32'h0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic drive_idle();
    inst_req = 1'b0; inst_wr = 1'b0; inst_size = 2'd0; inst_addr = 32'h0;
    inst_wdata = 32'h0; arready = 1'b0; rdata = 32'h0; rresp = 2'b00;
    rlast = 1'b0; rvalid = 1'b0;
  endtask

  task automatic drive_req(input logic wr, input logic [1:0] sz, input logic [31:0] a);
    inst_req = 1'b1; inst_wr = wr; inst_size = sz; inst_addr = a;
    inst_wdata = 32'h5A5A_5A5A;
  endtask

  task automatic drive_r(input logic [31:0] d, input logic [1:0] resp, input logic [31:0] expd);
    rvalid = 1'b1; rdata = d; rresp = resp; rlast = 1'b1;
    exp_q.push_back(expd);
  endtask

  task automatic drop_r();
    rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00; rlast = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    drive_idle();
    rst = 1'b1;
    cyc();
    cyc();
    // Request held during reset must not be acknowledged.
    drive_req(1'b0, 2'd2, 32'h1234_5678);
    smp();
    chk("rst_addr_ok", 32'(inst_addr_ok), 32'd0);
    chk("rst_data_ok", 32'(inst_data_ok), 32'd0);
    chk("rst_arvalid", 32'(arvalid), 32'd0);
    chk("rst_rready", 32'(rready), 32'd0);
    chk("rst_araddr", araddr, 32'h0);
    chk("rst_arsize", 32'(arsize), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    cyc();
    drive_idle();
    rst = 1'b0;
    smp();
    chk("post_rst_state", 32'(dbg_state), 32'(IDLE));

    // ---- zero-wait read ----
    cyc();
    drive_req(1'b0, 2'd2, 32'hBFC0_0004);
    smp();
    chk("t1_addr_ok", 32'(inst_addr_ok), 32'd1);
    chk("t1_arvalid_c0", 32'(arvalid), 32'd0);
    cyc();
    inst_req = 1'b0; arready = 1'b1;
    smp();
    chk("t1_arvalid", 32'(arvalid), 32'd1);
    chk("t1_araddr", araddr, 32'hBFC0_0004);
    chk("t1_arsize", 32'(arsize), 32'd2);
    chk("t1_arlen", 32'(arlen), 32'd0);
    chk("t1_arburst", 32'(arburst), 32'd1);
    chk("t1_arid", 32'(arid), 32'd0);
    chk("t1_rready_ar", 32'(rready), 32'd0);
    cyc();
    arready = 1'b0;
    drive_r(32'h2408_0001, 2'b00, 32'h2408_0001);
    smp();
    chk("t1_rready", 32'(rready), 32'd1);
    chk("t1_data_ok", 32'(inst_data_ok), 32'd1);
`ifdef IBRIDGE_RRESP_ERR_EN
    chk("t1_err", 32'(inst_err), 32'd0);
`endif
    cyc();
    drop_r();
    smp();
    chk("t1_data_ok_c3", 32'(inst_data_ok), 32'd0);
    chk("t1_state_c3", 32'(dbg_state), 32'(IDLE));
    chk("t1_rready_c3", 32'(rready), 32'd0);

    // ---- AR backpressure, byte read; req held with a changed address ----
    cyc();
    drive_req(1'b0, 2'd0, 32'h8000_0011);
    smp();
    chk("t2_addr_ok", 32'(inst_addr_ok), 32'd1);
    cyc();
    inst_addr = 32'hDEAD_BEEC;
    for (int i = 0; i < 5; i++) begin
      // An rvalid while waiting on AR must not be consumed.
      if (i == 2) begin rvalid = 1'b1; rdata = 32'hBAD0_BAD0; end
      else        begin rvalid = 1'b0; rdata = 32'h0; end
      smp();
      chk("t2_arvalid_hold", 32'(arvalid), 32'd1);
      chk("t2_araddr_hold", araddr, 32'h8000_0011);
      chk("t2_arsize_hold", 32'(arsize), 32'd0);
      chk("t2_no_addr_ok", 32'(inst_addr_ok), 32'd0);
      chk("t2_rready_low", 32'(rready), 32'd0);
      cyc();
    end
    drop_r();
    inst_req = 1'b0; arready = 1'b1;
    smp();
    chk("t2_arvalid_hs", 32'(arvalid), 32'd1);
    cyc();
    arready = 1'b0;
    drive_r(32'h1122_3344, 2'b00, 32'h1122_3344);
    smp();
    chk("t2_data_ok", 32'(inst_data_ok), 32'd1);
    cyc();
    drop_r();

    // ---- R backpressure, half read: rvalid 7 cycles after AR handshake ----
    drive_req(1'b0, 2'd1, 32'h0000_0102);
    smp();
    chk("t3_addr_ok", 32'(inst_addr_ok), 32'd1);
    cyc();
    inst_req = 1'b0; arready = 1'b1;
    smp();
    chk("t3_arsize", 32'(arsize), 32'd1);
    cyc();
    arready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      smp();
      chk("t3_rready_hold", 32'(rready), 32'd1);
      chk("t3_no_data_ok", 32'(inst_data_ok), 32'd0);
      cyc();
    end
    drive_r(32'hA5A5_0F0F, 2'b00, 32'hA5A5_0F0F);
    smp();
    chk("t3_data_ok", 32'(inst_data_ok), 32'd1);
    cyc();
    drop_r();
    smp();
    chk("t3_rready_off", 32'(rready), 32'd0);
    chk("t3_data_ok_off", 32'(inst_data_ok), 32'd0);

    // ---- write request: local ack, no AR ----
    cyc();
    drive_req(1'b1, 2'd2, 32'h0000_2000);
    exp_q.push_back(32'h0);
    smp();
    chk("t4_addr_ok", 32'(inst_addr_ok), 32'd1);
    cyc();
    inst_req = 1'b0;
    smp();
    chk("t4_data_ok", 32'(inst_data_ok), 32'd1);
    chk("t4_arvalid", 32'(arvalid), 32'd0);
    chk("t4_state", 32'(dbg_state), 32'(WACK));
    cyc();
    smp();
    chk("t4_arvalid_c2", 32'(arvalid), 32'd0);
    chk("t4_data_ok_c2", 32'(inst_data_ok), 32'd0);

    // ---- back-to-back reads, req held; size 3 maps to word ----
    cyc();
    drive_req(1'b0, 2'd3, 32'h0000_1000);
    smp();
    chk("t5_addr_ok_a", 32'(inst_addr_ok), 32'd1);
    cyc();
    inst_addr = 32'h0000_1004; arready = 1'b1;
    smp();
    chk("t5_araddr_a", araddr, 32'h0000_1000);
    chk("t5_arsize_a", 32'(arsize), 32'd2);
    chk("t5_no_addr_ok_ar", 32'(inst_addr_ok), 32'd0);
    cyc();
    arready = 1'b0;
    drive_r(32'h0000_AAAA, 2'b00, 32'h0000_AAAA);
    smp();
    chk("t5_no_addr_ok_r", 32'(inst_addr_ok), 32'd0);
    chk("t5_data_ok_a", 32'(inst_data_ok), 32'd1);
    cyc();
    drop_r();
    smp();
    chk("t5_addr_ok_b", 32'(inst_addr_ok), 32'd1);
    cyc();
    inst_req = 1'b0; arready = 1'b1;
    smp();
    chk("t5_arvalid_b", 32'(arvalid), 32'd1);
    chk("t5_araddr_b", araddr, 32'h0000_1004);
    cyc();
    arready = 1'b0;
    drive_r(32'h0000_BBBB, 2'b00, 32'h0000_BBBB);
    smp();
    chk("t5_data_ok_b", 32'(inst_data_ok), 32'd1);
    cyc();
    drop_r();

    // ---- reset while waiting in R ----
    drive_req(1'b0, 2'd2, 32'h0000_3000);
    cyc();
    inst_req = 1'b0; arready = 1'b1;
    cyc();
    arready = 1'b0;
    smp();
    chk("t6_state_r", 32'(dbg_state), 32'(R));
    cyc();
    rst = 1'b1;
    smp();
    chk("t6_data_ok_rst", 32'(inst_data_ok), 32'd0);
    cyc();
    rst = 1'b0;
    rvalid = 1'b1; rdata = 32'hDEAD_0000;  // stale beat, must not complete
    smp();
    chk("t6_state", 32'(dbg_state), 32'(IDLE));
    chk("t6_rready", 32'(rready), 32'd0);
    chk("t6_arvalid", 32'(arvalid), 32'd0);
    chk("t6_data_ok", 32'(inst_data_ok), 32'd0);
    cyc();
    drop_r();

`ifdef IBRIDGE_RRESP_ERR_EN
    // ---- error response: data forced to zero, inst_err pulses ----
    drive_req(1'b0, 2'd2, 32'h0000_4000);
    cyc();
    inst_req = 1'b0; arready = 1'b1;
    cyc();
    arready = 1'b0;
    drive_r(32'hCAFE_F00D, 2'b10, 32'h0);
    smp();
    chk("t7_data_ok", 32'(inst_data_ok), 32'd1);
    chk("t7_err", 32'(inst_err), 32'd1);
    cyc();
    drop_r();
    smp();
    chk("t7_err_off", 32'(inst_err), 32'd0);
    cyc();
`endif

    cyc();
    smp();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
